rr_arb16_dec: RTL

//   Round-robin arbiter that shares one resource among 16 requesters.

---
 rtl/arb16_pkg.sv | 14 +
 rtl/dec4to16_en.sv | 15 +
 rtl/rr_arb16_dec.sv | 114 +++++++++++
 3 files changed

// File: rtl/arb16_pkg.sv
// Shared constants and state encoding for the 16-way round-robin arbiter.
package arb16_pkg;

  localparam int unsigned N_REQ    = 16;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned MAX_HOLD = 8;
  localparam int unsigned HOLD_W   = $clog2(MAX_HOLD);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/dec4to16_en.sv
// Enable-gated index-to-one-hot decoder; all-zero output when disabled.
module dec4to16_en
  import arb16_pkg::*;
(
  input  logic [IDX_W-1:0] sel,
  input  logic             en,
  output logic [N_REQ-1:0] out
);

  always_comb begin
    out = '0;
    if (en) out[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_arb16_dec.sv
// Round-robin arbiter for 16 requesters with hold timeout; grant held until
// done, request withdrawal or timeout, then one idle cycle before the next grant.
module rr_arb16_dec
  import arb16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout
);

  state_e            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]  r_gnt_idx, w_gnt_idx_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic              r_gnt_valid, w_gnt_valid_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic [IDX_W-1:0]  w_pick;
  logic              w_any_req, w_rel_done, w_rel_wd, w_rel_lim, w_release;

  // First set request scanning ptr, ptr+1, ... with natural index wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    win = p;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      idx = p + IDX_W'(k);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  assign w_pick     = rr_pick(req, r_ptr);
  assign w_any_req  = |req;
  assign w_rel_done = done;
  assign w_rel_wd   = ~req[r_gnt_idx];
  assign w_rel_lim  = (r_hold == HOLD_W'(MAX_HOLD - 1));
  assign w_release  = w_rel_done | w_rel_wd | w_rel_lim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_state_nxt = ST_GRANT;
      ST_GRANT: if (w_release) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ptr_nxt       = r_ptr;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_hold_nxt      = r_hold;
    w_gnt_valid_nxt = r_gnt_valid;
    w_timeout_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_gnt_valid_nxt = 1'b0;
        if (w_any_req) begin
          w_gnt_idx_nxt   = w_pick;
          w_gnt_valid_nxt = 1'b1;
          w_hold_nxt      = '0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_gnt_valid_nxt = 1'b0;
          w_ptr_nxt       = r_gnt_idx + IDX_W'(1);
          // Timeout flagged only when the limit alone forced the release.
          w_timeout_nxt   = w_rel_lim & ~w_rel_done & ~w_rel_wd;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: w_gnt_valid_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_gnt_idx   <= '0;
      r_hold      <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_hold      <= w_hold_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  dec4to16_en u_dec (
    .sel (r_gnt_idx),
    .en  (r_gnt_valid),
    .out (gnt)
  );

  assign gnt_valid = r_gnt_valid;
  assign gnt_idx   = r_gnt_idx;
  assign timeout   = r_timeout;

endmodule
